// File: rtl/clk_divider_multi_pkg.sv
// Shared defaults for the multi-channel clock divider.
package clk_divider_multi_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIDTH = 16;
    localparam int MIN_DIV   = 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: live counter and outputs, plus a shadow config that only
// takes effect at a period boundary, on sync_start, or while the channel is idle.
module clk_div_channel
    import clk_divider_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_start,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0] wr_duty,
    output logic             pending,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    // ceil(div/2) is formed as (div>>1)+div[0] so it cannot overflow at the max div.
    function automatic logic [WIDTH-1:0] high_cycles(input logic [WIDTH-1:0] div,
                                                     input logic [WIDTH-1:0] duty);
        logic [WIDTH-1:0] hi;
        if (duty == ZERO_W) begin
            hi = (div >> 1) + {{(WIDTH-1){1'b0}}, div[0]};
        end else begin
            hi = duty;
        end
        return hi;
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] shd_div_r;
    logic [WIDTH-1:0] shd_duty_r;
    logic [WIDTH-1:0] hi_s;
    logic             pend_r;
    logic             clk_out_r;
    logic             tick_r;
    logic             active_r;
    logic             run_s;
    logic             wrap_s;
    logic             restart_s;
    logic             apply_s;

    // Run, wrap, restart and shadow-apply decode for the current cycle.
    always_comb begin
        run_s     = en && (div_r >= MIN_DIV_W);
        wrap_s    = (cnt_r == (div_r - ONE_W));
        restart_s = run_s && sync_start;
        apply_s   = pend_r && (restart_s || wrap_s || !run_s);
        hi_s      = high_cycles(div_r, duty_r);
    end

    // Counter and registered outputs; an idle or disabled channel parks at count 0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= ZERO_W;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            active_r  <= 1'b0;
        end else if (run_s) begin
            clk_out_r <= (cnt_r < hi_s);
            tick_r    <= (cnt_r == ZERO_W);
            active_r  <= 1'b1;
            cnt_r     <= (restart_s || wrap_s) ? ZERO_W : (cnt_r + ONE_W);
        end else begin
            cnt_r     <= ZERO_W;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            active_r  <= 1'b0;
        end
    end

    // Shadow capture and apply; ready gating means a write never meets an apply here.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shd_div_r  <= ZERO_W;
            shd_duty_r <= ZERO_W;
            div_r      <= ZERO_W;
            duty_r     <= ZERO_W;
            pend_r     <= 1'b0;
        end else begin
            if (apply_s) begin
                div_r  <= shd_div_r;
                duty_r <= shd_duty_r;
            end else begin
                div_r  <= div_r;
                duty_r <= duty_r;
            end
            if (wr) begin
                shd_div_r  <= wr_div;
                shd_duty_r <= wr_duty;
                pend_r     <= 1'b1;
            end else if (apply_s) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign pending = pend_r;
    assign clk_out = clk_out_r;
    assign tick    = tick_r;
    assign active  = active_r;

endmodule

// File: rtl/clk_divider_multi.sv
// NCH-channel programmable clock divider: config decode, ready mux and
// sync_start fanout around one clk_div_channel per channel.
module clk_divider_multi
    import clk_divider_multi_pkg::*;
#(
    parameter  int NCH   = DEF_NCH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   active
);

    logic [NCH-1:0]        pend_s;
    logic [NCH-1:0]        wr_s;
    logic [(2**CHW)-1:0]   pend_ext_s;

    // Unpopulated channel codes read as never pending, so writes to them are dropped.
    always_comb begin
        pend_ext_s          = '0;
        pend_ext_s[NCH-1:0] = pend_s;
    end

    assign cfg_ready = ~pend_ext_s[cfg_ch];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_s[i] = cfg_valid & cfg_ready & (cfg_ch == CHW'(i));

        clk_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .en        (en[i]),
            .sync_start(sync_start),
            .wr        (wr_s[i]),
            .wr_div    (cfg_div),
            .wr_duty   (cfg_duty),
            .pending   (pend_s[i]),
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .active    (active[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: spec-derived expected waveforms
// are queued per scenario and popped against the DUT one cycle at a time.
module tb_clk_divider_multi;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;
    localparam int CHW   = 2;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   en;
    logic             sync_start;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_duty;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   active;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    clk_divider_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .sync_start(sync_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Returns just after the accept edge; a stuck cfg_ready counts as a failure.
    task automatic cfg_write(input int ch, input logic [WIDTH-1:0] div, input logic [WIDTH-1:0] duty);
        int guard;
        guard     = 0;
        cfg_ch    = ch[CHW-1:0];
        cfg_div   = div;
        cfg_duty  = duty;
        cfg_valid = 1'b1;
        #1;
        while (cfg_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL cfg_write_timeout ch%0d: cfg_ready=%b, required 1", ch, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; sync_start = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_duty = '0;
        repeat (3) step();
        #2 rst_n = 1'b1;
        step();
        n_checks++; if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_out: got %b, required 0000", clk_out); end
        n_checks++; if (tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick: got %b, required 0000", tick); end
        n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL reset_active: got %b, required 0000", active); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
    endtask

    task automatic test_div4();
        logic [7:0] got, exp;
        cfg_write(0, 16'd4, 16'd0);
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL div4_pending_ready: got %b, required 0", cfg_ready); end
        step();
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div4_idle_apply_ready: got %b, required 1", cfg_ready); end
        en[0] = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back({6'b0, ((k % 4) < 2), ((k % 4) == 0)});
        for (int k = 0; k < 8; k++) begin
            step();
            got = {6'b0, clk_out[0], tick[0]};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL div4 cycle %0d: got %b, required %b", k, got[1:0], exp[1:0]); end
        end
        n_checks++; if (active[0] !== 1'b1) begin n_fail++; $display("FAIL div4_active: got %b, required 1", active[0]); end
    endtask

    task automatic test_odd_and_stuck();
        logic [7:0] got, exp;
        cfg_write(1, 16'd5, 16'd0);
        cfg_write(2, 16'd7, 16'd9);
        step();
        en[2:1] = 2'b11;
        for (int k = 0; k < 14; k++)
            exp_q.push_back({4'b0, ((k % 5) < 3), ((k % 5) == 0), 1'b1, ((k % 7) == 0)});
        for (int k = 0; k < 14; k++) begin
            step();
            got = {4'b0, clk_out[1], tick[1], clk_out[2], tick[2]};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL odd_stuck cycle %0d: got %b, required %b", k, got[3:0], exp[3:0]); end
        end
        n_checks++; if (active[2:1] !== 2'b11) begin n_fail++; $display("FAIL odd_stuck_active: got %b, required 11", active[2:1]); end
    endtask

    task automatic test_reconfig();
        logic [7:0] got, exp;
        logic       c, t;
        en[0] = 1'b0;
        step();
        cfg_write(0, 16'd10, 16'd0);
        step();
        en[0] = 1'b1;
        for (int k = 0; k < 17; k++) begin
            t = (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
            c = (k < 10) ? (k < 5) : (((k - 10) % 3) < 2);
            exp_q.push_back({6'b0, c, t});
        end
        for (int k = 0; k < 17; k++) begin
            step();
            got = {6'b0, clk_out[0], tick[0]};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL reconfig cycle %0d: got %b, required %b", k, got[1:0], exp[1:0]); end
            if (k == 1) begin
                cfg_ch = 2'd0; cfg_div = 16'd3; cfg_duty = 16'd0; cfg_valid = 1'b1;
            end else if (k == 2) begin
                cfg_div = 16'd6;
            end else if (k == 6) begin
                cfg_valid = 1'b0;
            end
            if (k >= 2 && k <= 8) begin
                n_checks++;
                if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reconfig_stall cycle %0d: cfg_ready=%b, required 0", k, cfg_ready); end
            end
            if (k == 9) begin
                n_checks++;
                if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconfig_apply_ready: got %b, required 1", cfg_ready); end
            end
        end
    endtask

    task automatic test_sync_start();
        logic [7:0] got, exp;
        int         d;
        en = '0;
        step();
        cfg_write(0, 16'd3, 16'd0);
        cfg_write(1, 16'd4, 16'd0);
        cfg_write(2, 16'd6, 16'd0);
        step();
        en[0] = 1'b1; repeat (2) step();
        en[1] = 1'b1; step();
        en[2] = 1'b1; repeat (2) step();
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp = 8'b0;
            for (int ch = 0; ch < 3; ch++) begin
                d = (ch == 0) ? 3 : ((ch == 1) ? 4 : 6);
                exp[4 + ch] = (((k - 1) % d) < ((d + 1) / 2));
                exp[ch]     = (((k - 1) % d) == 0);
            end
            exp_q.push_back(exp);
        end
        for (int k = 1; k <= 13; k++) begin
            step();
            got = {clk_out, tick};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sync cycle %0d: got %b, required %b", k, got, exp); end
        end
    endtask

    task automatic test_idle_and_max();
        logic [2:0] got;
        int         hi_cnt;
        en = '0;
        step();
        for (int v = 0; v < 2; v++) begin
            cfg_write(3, WIDTH'(v), 16'd0);
            en[3] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                step();
                got = {active[3], clk_out[3], tick[3]};
                n_checks++;
                if (got !== 3'b000) begin n_fail++; $display("FAIL idle_div%0d cycle %0d: got %b, required 000", v, k, got); end
            end
            n_checks++;
            if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_div%0d_ready: got %b, required 1", v, cfg_ready); end
        end
        cfg_write(0, 16'hFFFF, 16'd0);
        step();
        en[0] = 1'b1;
        step();
        n_checks++;
        if ({clk_out[0], tick[0]} !== 2'b11) begin n_fail++; $display("FAIL max_first: got %b, required 11", {clk_out[0], tick[0]}); end
        hi_cnt = 0;
        while (clk_out[0] === 1'b1 && hi_cnt < 40000) begin
            hi_cnt++;
            step();
        end
        n_checks++;
        if (hi_cnt != 32768) begin n_fail++; $display("FAIL max_high_len: got %0d, required 32768", hi_cnt); end
    endtask

    task automatic test_async_reset();
        en[1] = 1'b1;
        repeat (2) step();
        n_checks++;
        if (active !== 4'b0011) begin n_fail++; $display("FAIL pre_reset_active: got %b, required 0011", active); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL async_clk_out: got %b, required 0000", clk_out); end
        n_checks++; if (tick !== 4'b0000) begin n_fail++; $display("FAIL async_tick: got %b, required 0000", tick); end
        n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL async_active: got %b, required 0000", active); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL async_cfg_ready: got %b, required 1", cfg_ready); end
        step();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({active, clk_out, tick} !== 12'h000) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle %0d: got %b/%b/%b, required all 0", k, active, clk_out, tick);
            end
        end
        cfg_write(1, 16'd4, 16'd0);
        repeat (2) step();
        n_checks++;
        if ({active[1], clk_out[1], tick[1]} !== 3'b111) begin
            n_fail++;
            $display("FAIL post_reset_reconfig: got %b, required 111", {active[1], clk_out[1], tick[1]});
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_odd_and_stuck();
        test_reconfig();
        test_sync_start();
        test_idle_and_max();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
